ball_motion_fsm: RTL and testbench



---
 rtl/ball_motion_fsm.sv | 182 ++++++++++++++++++
 tb/tb_ball_motion_fsm.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/ball_motion_fsm.sv
// rtl/ball_motion_fsm.sv - ball motion integrator and game-state FSM
//
// Ports:
//   clk, resetN            clock, asynchronous active-low reset
//   startOfFrame           one-cycle pulse per frame; advances position / respawn timer
//   launch                 starts play from IDLE
//   collision, HitEdgeCode collision strobe and hit edge {left, top, right, bottom}
//   lostBall, win          ball lost below paddle / all bricks cleared
//   turbo                  level; multiplies speed by 2^TURBO_SHIFT
//   lives, state, gameOver game status
//   topLeftX, topLeftY     integer pixel position (floor of fixed-point position)
module ball_motion_fsm #(
    parameter int INITIAL_X      = 317,
    parameter int INITIAL_Y      = 411,
    parameter int RESPAWN_Y      = 320,
    parameter int BASE_SPEED     = 150,
    parameter int TURBO_SHIFT    = 1,
    parameter int FRAC_BITS      = 6,
    parameter int INITIAL_LIVES  = 3,
    parameter int LIVES_W        = 4,
    parameter int RESPAWN_FRAMES = 30,
    parameter int X_MIN          = 40
) (
    input  logic                clk,
    input  logic                resetN,
    input  logic                startOfFrame,
    input  logic                launch,
    input  logic                collision,
    input  logic [3:0]          HitEdgeCode,
    input  logic                lostBall,
    input  logic                win,
    input  logic                turbo,
    output logic [LIVES_W-1:0]  lives,
    output logic [2:0]          state,
    output logic                gameOver,
    output logic signed [10:0]  topLeftX,
    output logic signed [10:0]  topLeftY
);

    localparam int POS_W = 11 + FRAC_BITS;
    localparam int CNT_W = (RESPAWN_FRAMES < 2) ? 1 : $clog2(RESPAWN_FRAMES + 1);

    localparam logic signed [POS_W-1:0] INIT_POS_X = POS_W'(INITIAL_X * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] INIT_POS_Y = POS_W'(INITIAL_Y * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] RESP_POS_Y = POS_W'(RESPAWN_Y * (2 ** FRAC_BITS));
    localparam logic signed [POS_W-1:0] MAG_NORM   = POS_W'(BASE_SPEED);
    localparam logic signed [POS_W-1:0] MAG_TURBO  = POS_W'(BASE_SPEED * (2 ** TURBO_SHIFT));
    localparam logic [9:0]              LFSR_SEED  = 10'h2A5;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MOVING    = 3'd1,
        S_RESPAWN   = 3'd2,
        S_GAME_OVER = 3'd3,
        S_WON       = 3'd4
    } state_e;

    state_e                    state_q, state_d;
    logic signed [POS_W-1:0]   pos_x_q, pos_x_d;
    logic signed [POS_W-1:0]   pos_y_q, pos_y_d;
    logic                      dir_x_q, dir_x_d;
    logic                      dir_y_q, dir_y_d;
    logic [LIVES_W-1:0]        lives_q, lives_d;
    logic                      game_over_q, game_over_d;
    logic [9:0]                lfsr_q, lfsr_d;
    logic [CNT_W-1:0]          frame_cnt_q, frame_cnt_d;

    logic signed [POS_W-1:0]   mag;
    logic [POS_W-1:0]          respawn_x;
    logic signed [POS_W-1:0]   shifted_x, shifted_y;

    assign mag       = turbo ? MAG_TURBO : MAG_NORM;
    // Respawn column spans X_MIN .. X_MIN+511, picked by the low nine LFSR bits.
    assign respawn_x = (POS_W'(X_MIN) + POS_W'(lfsr_q[8:0])) << FRAC_BITS;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state_q     <= S_IDLE;
            pos_x_q     <= INIT_POS_X;
            pos_y_q     <= INIT_POS_Y;
            dir_x_q     <= 1'b1;
            dir_y_q     <= 1'b0;
            lives_q     <= LIVES_W'(INITIAL_LIVES);
            game_over_q <= 1'b0;
            lfsr_q      <= LFSR_SEED;
            frame_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            dir_x_q     <= dir_x_d;
            dir_y_q     <= dir_y_d;
            lives_q     <= lives_d;
            game_over_q <= game_over_d;
            lfsr_q      <= lfsr_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        pos_x_d     = pos_x_q;
        pos_y_d     = pos_y_q;
        dir_x_d     = dir_x_q;
        dir_y_d     = dir_y_q;
        lives_d     = lives_q;
        frame_cnt_d = frame_cnt_q;
        // Fibonacci LFSR x^10 + x^7 + 1, free-running in every state.
        lfsr_d      = {lfsr_q[8:0], lfsr_q[9] ^ lfsr_q[6]};

        case (state_q)
            S_IDLE: begin
                if (win) begin
                    state_d = S_WON;
                end else if (launch) begin
                    state_d = S_MOVING;
                    dir_x_d = 1'b1;
                    dir_y_d = 1'b0;
                end
            end
            S_MOVING: begin
                if (win) begin
                    state_d = S_WON;
                end else if (lostBall) begin
                    // Respawn/game-over load overrides any same-cycle motion.
                    if (lives_q <= LIVES_W'(1)) begin
                        state_d = S_GAME_OVER;
                        lives_d = '0;
                    end else begin
                        state_d     = S_RESPAWN;
                        lives_d     = lives_q - LIVES_W'(1);
                        pos_x_d     = $signed(respawn_x);
                        pos_y_d     = RESP_POS_Y;
                        dir_x_d     = lfsr_q[9];
                        dir_y_d     = 1'b0;
                        frame_cnt_d = CNT_W'(RESPAWN_FRAMES);
                    end
                end else begin
                    // Motion uses the registered direction, so a same-cycle
                    // reflection only takes effect from the next frame.
                    if (startOfFrame) begin
                        pos_x_d = dir_x_q ? pos_x_q + mag : pos_x_q - mag;
                        pos_y_d = dir_y_q ? pos_y_q + mag : pos_y_q - mag;
                    end
                    if (collision) begin
                        if (HitEdgeCode[3] && !dir_x_q) dir_x_d = 1'b1;
                        if (HitEdgeCode[1] &&  dir_x_q) dir_x_d = 1'b0;
                        if (HitEdgeCode[2] && !dir_y_q) dir_y_d = 1'b1;
                        if (HitEdgeCode[0] &&  dir_y_q) dir_y_d = 1'b0;
                    end
                end
            end
            S_RESPAWN: begin
                if (win) begin
                    state_d = S_WON;
                end else if (startOfFrame) begin
                    if (frame_cnt_q == CNT_W'(1)) begin
                        state_d     = S_MOVING;
                        frame_cnt_d = '0;
                    end else begin
                        frame_cnt_d = frame_cnt_q - CNT_W'(1);
                    end
                end
            end
            default: begin
                // GAME_OVER and WON hold everything until reset.
            end
        endcase

        game_over_d = (state_d == S_GAME_OVER);
    end

    assign shifted_x = pos_x_q >>> FRAC_BITS;
    assign shifted_y = pos_y_q >>> FRAC_BITS;

    assign state    = state_q;
    assign lives    = lives_q;
    assign gameOver = game_over_q;
    assign topLeftX = shifted_x[10:0];
    assign topLeftY = shifted_y[10:0];

endmodule

// File: tb/tb_ball_motion_fsm.sv
// tb/tb_ball_motion_fsm.sv - self-checking bench for ball_motion_fsm
module tb_ball_motion_fsm;

    logic               clk;
    logic               resetN;
    logic               startOfFrame;
    logic               launch;
    logic               collision;
    logic [3:0]         HitEdgeCode;
    logic               lostBall;
    logic               win;
    logic               turbo;
    logic [3:0]         lives;
    logic [2:0]         state;
    logic               gameOver;
    logic signed [10:0] topLeftX;
    logic signed [10:0] topLeftY;

    int n_tests = 0;
    int n_fail  = 0;

    ball_motion_fsm dut (
        .clk          (clk),
        .resetN       (resetN),
        .startOfFrame (startOfFrame),
        .launch       (launch),
        .collision    (collision),
        .HitEdgeCode  (HitEdgeCode),
        .lostBall     (lostBall),
        .win          (win),
        .turbo        (turbo),
        .lives        (lives),
        .state        (state),
        .gameOver     (gameOver),
        .topLeftX     (topLeftX),
        .topLeftY     (topLeftY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       sof;
        logic       lnch;
        logic       coll;
        logic [3:0] hit;
        logic       lost;
        logic       w;
        logic       trb;
        int         exp_state;
        int         exp_lives;
        int         exp_x;
        int         exp_y;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input logic sof, input logic lnch, input logic coll,
                        input logic [3:0] hit, input logic lost, input logic w,
                        input logic trb);
        startOfFrame = sof;
        launch       = lnch;
        collision    = coll;
        HitEdgeCode  = hit;
        lostBall     = lost;
        win          = w;
        turbo        = trb;
        @(posedge clk);
        #1;
        startOfFrame = 1'b0;
        launch       = 1'b0;
        collision    = 1'b0;
        HitEdgeCode  = 4'b0000;
        lostBall     = 1'b0;
        win          = 1'b0;
        turbo        = 1'b0;
    endtask

    task automatic sof_until_moving(input int max_frames);
        int k;
        k = 0;
        while (state != 3'd1 && k < max_frames) begin
            step(1, 0, 0, 4'b0000, 0, 0, 0);
            k++;
        end
        chk("respawn_exit_bound", int'(state), 1);
    endtask

    task automatic do_reset();
        resetN = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        resetN = 1'b1;
    endtask

    int rx, ry;

    initial begin
        // Expected positions from 317*64=20288 and 411*64=26304, speed 150 (300 turbo).
        vecs[0]  = '{0,0,0,4'b0000,0,0,0, 0,3,317,411};   // idle after reset
        vecs[1]  = '{0,1,0,4'b0000,0,0,0, 1,3,317,411};   // launch
        vecs[2]  = '{1,0,0,4'b0000,0,0,0, 1,3,319,408};   // 20438, 26154
        vecs[3]  = '{1,0,0,4'b0000,0,0,1, 1,3,324,403};   // turbo: 20738, 25854
        vecs[4]  = '{0,0,1,4'b0010,0,0,0, 1,3,324,403};   // right hit -> dirX=0
        vecs[5]  = '{1,0,0,4'b0000,0,0,0, 1,3,321,401};   // 20588, 25704
        vecs[6]  = '{1,0,1,4'b0010,0,0,0, 1,3,319,399};   // repeat right hit: no flip; 20438, 25554
        vecs[7]  = '{1,0,1,4'b0100,0,0,0, 1,3,317,396};   // top hit + frame: old dir; 20288, 25404
        vecs[8]  = '{1,0,0,4'b0000,0,0,0, 1,3,314,399};   // now down-left: 20138, 25554
        vecs[9]  = '{0,0,1,4'b1111,0,0,0, 1,3,314,399};   // left sets dirX=1, bottom clears dirY
        vecs[10] = '{1,0,0,4'b0000,0,0,0, 1,3,317,396};   // 20288, 25404

        startOfFrame = 0; launch = 0; collision = 0; HitEdgeCode = 0;
        lostBall = 0; win = 0; turbo = 0;
        do_reset();

        chk("reset_gameOver", int'(gameOver), 0);
        for (int i = 0; i < 11; i++) begin
            step(vecs[i].sof, vecs[i].lnch, vecs[i].coll, vecs[i].hit,
                 vecs[i].lost, vecs[i].w, vecs[i].trb);
            chk($sformatf("vec%0d_state", i), int'(state), vecs[i].exp_state);
            chk($sformatf("vec%0d_lives", i), int'(lives), vecs[i].exp_lives);
            chk($sformatf("vec%0d_x", i), int'(topLeftX), vecs[i].exp_x);
            chk($sformatf("vec%0d_y", i), int'(topLeftY), vecs[i].exp_y);
        end

        // Loss with a same-cycle frame: respawn load wins.
        step(1, 0, 0, 4'b0000, 1, 0, 0);
        chk("loss1_state", int'(state), 2);
        chk("loss1_lives", int'(lives), 2);
        chk("loss1_y", int'(topLeftY), 320);
        rx = int'(topLeftX);
        ry = int'(topLeftY);
        n_tests++;
        if (rx < 40 || rx > 551) begin
            n_fail++;
            $display("FAIL loss1_x_range: got %0d expected 40..551", rx);
        end
        // 29 frames stay in RESPAWN with position frozen; one lostBall is ignored.
        for (int f = 0; f < 29; f++) begin
            step(1, 0, (f == 3), 4'b1111, (f == 5), 0, 0);
            chk($sformatf("resp_f%0d_state", f), int'(state), 2);
            chk($sformatf("resp_f%0d_x", f), int'(topLeftX), rx);
            chk($sformatf("resp_f%0d_y", f), int'(topLeftY), ry);
        end
        chk("resp_lives_after_lost", int'(lives), 2);
        step(1, 0, 0, 4'b0000, 0, 0, 0);
        chk("resp_exit_state", int'(state), 1);

        // Two more losses end the game.
        step(0, 0, 0, 4'b0000, 1, 0, 0);
        chk("loss2_state", int'(state), 2);
        chk("loss2_lives", int'(lives), 1);
        sof_until_moving(40);
        step(0, 0, 0, 4'b0000, 1, 0, 0);
        chk("loss3_state", int'(state), 3);
        chk("loss3_lives", int'(lives), 0);
        chk("loss3_gameOver", int'(gameOver), 1);
        rx = int'(topLeftX);
        ry = int'(topLeftY);
        for (int f = 0; f < 4; f++) begin
            step(1, 1, 1, 4'b1111, 1, 0, f[0]);
            chk($sformatf("go_f%0d_state", f), int'(state), 3);
            chk($sformatf("go_f%0d_lives", f), int'(lives), 0);
            chk($sformatf("go_f%0d_x", f), int'(topLeftX), rx);
            chk($sformatf("go_f%0d_y", f), int'(topLeftY), ry);
        end

        // Fresh game: one loss, back to MOVING, then win + lostBall together.
        do_reset();
        chk("reset2_state", int'(state), 0);
        step(0, 1, 0, 4'b0000, 0, 0, 0);
        step(0, 0, 0, 4'b0000, 1, 0, 0);
        chk("g2_loss_lives", int'(lives), 2);
        sof_until_moving(40);
        step(1, 0, 0, 4'b0000, 0, 0, 0);
        rx = int'(topLeftX);
        ry = int'(topLeftY);
        step(0, 0, 0, 4'b0000, 1, 1, 0);
        chk("win_state", int'(state), 4);
        chk("win_lives", int'(lives), 2);
        chk("win_gameOver", int'(gameOver), 0);
        for (int f = 0; f < 3; f++) begin
            step(1, 1, 1, 4'b1111, 1, 0, 0);
            chk($sformatf("won_f%0d_x", f), int'(topLeftX), rx);
            chk($sformatf("won_f%0d_y", f), int'(topLeftY), ry);
            chk($sformatf("won_f%0d_state", f), int'(state), 4);
        end

        // Asynchronous reset: values restored without a clock edge.
        resetN = 1'b0;
        #2;
        chk("async_state", int'(state), 0);
        chk("async_lives", int'(lives), 3);
        chk("async_x", int'(topLeftX), 317);
        chk("async_y", int'(topLeftY), 411);
        chk("async_gameOver", int'(gameOver), 0);
        @(posedge clk);
        #1;
        resetN = 1'b1;

        // Win straight from IDLE.
        step(0, 1, 0, 4'b0000, 0, 1, 0);
        chk("idle_win_state", int'(state), 4);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
